// File: rtl/dispense_valve_ctrl.sv
// Beverage dispense valve controller: takes a beverage code, waits for a cup,
// pours for a fixed time and tracks per-valve servings.
module dispense_valve_ctrl #(
    parameter int unsigned POUR_CYCLES = 20,
    parameter int unsigned CUP_TIMEOUT = 50,
    parameter int unsigned STOCK_W     = 4,
    parameter int unsigned STOCK_MAX   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Despacho,
    input  logic       Cup,
    input  logic       Clear,
    input  logic       Refill,
    output logic [7:0] Valve,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [1:0] ErrCode,
    output logic [7:0] Empty
);

    // One shared down-counter serves both the cup wait and the pour timer.
    localparam int unsigned CntMax = (CUP_TIMEOUT > POUR_CYCLES) ? CUP_TIMEOUT : POUR_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0]    WaitLoad  = CntW'(CUP_TIMEOUT - 1);
    localparam logic [CntW-1:0]    PourLoad  = CntW'(POUR_CYCLES - 1);
    localparam logic [STOCK_W-1:0] StockFull = STOCK_W'(STOCK_MAX);

    typedef enum logic [2:0] {StIdle, StWaitCup, StPour, StDone, StFault} state_e;

    state_e             state_q, state_d;
    logic [4:0]         desp_prev_q;
    logic [2:0]         idx_q, idx_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic [STOCK_W-1:0] stock_q [8];
    logic [STOCK_W-1:0] stock_d [8];
    logic               req;
    logic               code_ok;
    logic               pour_end;
    logic [4:0]         code_m1;

    // A request is the rising transition of Despacho away from zero.
    assign req     = (Despacho != 5'd0) && (desp_prev_q == 5'd0);
    assign code_ok = (Despacho <= 5'd8);
    assign code_m1 = Despacho - 5'd1;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: edge detector, latched valve index, timer, error code, stock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            desp_prev_q <= 5'd0;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            err_q       <= 2'b00;
            for (int k = 0; k < 8; k++) begin
                stock_q[k] <= StockFull;
            end
        end else begin
            desp_prev_q <= Despacho;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            for (int k = 0; k < 8; k++) begin
                stock_q[k] <= stock_d[k];
            end
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pour_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && code_ok) begin
                    idx_d = code_m1[2:0];
                    if (stock_q[code_m1[2:0]] == '0) begin
                        state_d = StFault;
                        err_d   = 2'b01;
                    end else begin
                        state_d = StWaitCup;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWaitCup: begin
                if (Cup) begin
                    state_d = StPour;
                    cnt_d   = PourLoad;
                end else if (cnt_q == '0) begin
                    state_d = StFault;
                    err_d   = 2'b10;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPour: begin
                if (!Cup) begin
                    state_d = StFault;
                    err_d   = 2'b11;
                end else if (cnt_q == '0) begin
                    state_d  = StDone;
                    pour_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StFault: begin
                if (Clear) begin
                    state_d = StIdle;
                    err_d   = 2'b00;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stock update: refill first, then the completed serving is taken off.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            stock_d[k] = Refill ? StockFull : stock_q[k];
            if (pour_end && (idx_q == 3'(k)) && (stock_d[k] != '0)) begin
                stock_d[k] = stock_d[k] - 1'b1;
            end
        end
    end

    // Moore outputs decoded from state; valve closes as soon as state leaves StPour.
    always_comb begin
        Valve = 8'd0;
        Busy  = (state_q != StIdle);
        Done  = (state_q == StDone);
        Error = (state_q == StFault);
        if (state_q == StPour) begin
            Valve[idx_q] = 1'b1;
        end
    end

    // Empty flags straight from the stock counters.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            Empty[k] = (stock_q[k] == '0);
        end
    end

    assign ErrCode = err_q;

endmodule

// File: tb/tb_dispense_valve_ctrl.sv
// Self-checking bench for dispense_valve_ctrl: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_dispense_valve_ctrl;

    localparam int POUR = 20;
    localparam int TO   = 50;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Despacho;
    logic       Cup, Clear, Refill;
    logic [7:0] Valve;
    logic       Busy, Done, Error;
    logic [1:0] ErrCode;
    logic [7:0] Empty;

    always #5 clk = ~clk;

    dispense_valve_ctrl #(
        .POUR_CYCLES(POUR),
        .CUP_TIMEOUT(TO),
        .STOCK_W    (4),
        .STOCK_MAX  (SMAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Despacho(Despacho),
        .Cup     (Cup),
        .Clear   (Clear),
        .Refill  (Refill),
        .Valve   (Valve),
        .Busy    (Busy),
        .Done    (Done),
        .Error   (Error),
        .ErrCode (ErrCode),
        .Empty   (Empty)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state and predictions
    int   m_stock [8];
    bit   exp_err;
    int   exp_code, exp_t, exp_vc;
    logic [7:0] exp_empty;

    // Observations from the transaction driver
    bit   obs_err, obs_onehot_ok;
    logic [1:0] obs_code, obs_errcode_after;
    int   obs_t, obs_vc;
    logic obs_busy_after, obs_done_after, obs_error_after;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_refill();
        for (int k = 0; k < 8; k++) m_stock[k] = SMAX;
    endtask

    task automatic model_empty();
        for (int k = 0; k < 8; k++) exp_empty[k] = (m_stock[k] == 0);
    endtask

    // Outcome of one request from the spec rules. t counts cycles from the first
    // cycle after the request edge to the cycle in which Done/Error is first seen.
    task automatic predict(input int code, input int d, input bit drop, input int p,
                           input bit refill_last);
        int idx = code - 1;
        if (m_stock[idx] == 0) begin
            exp_err = 1; exp_code = 1; exp_t = 0; exp_vc = 0;
        end else if (d >= TO) begin
            exp_err = 1; exp_code = 2; exp_t = TO; exp_vc = 0;
        end else if (drop && p < POUR) begin
            exp_err = 1; exp_code = 3; exp_t = d + 2 + p; exp_vc = p + 1;
        end else begin
            exp_err = 0; exp_code = 0; exp_t = d + 1 + POUR; exp_vc = POUR;
            if (refill_last) model_refill();
            m_stock[idx] = m_stock[idx] - 1;
        end
        model_empty();
    endtask

    // Drives one request; cup appears d cycles in, optionally leaves at pour cycle p.
    task automatic run_txn(input int code, input int d, input bit drop, input int p,
                           input bit hold, input int inj, input bit refill_last);
        int t = 0;
        bit fin = 0;
        Despacho = 5'd0; Cup = 1'b0; Clear = 1'b0; Refill = 1'b0;
        step();
        Despacho = 5'(code);
        step();
        obs_err = 0; obs_vc = 0; obs_t = -1; obs_code = 2'b00; obs_onehot_ok = 1;
        while (!fin && t < 300) begin
            if (Valve != 8'd0) begin
                obs_vc++;
                if (Valve !== 8'(1 << (code - 1))) obs_onehot_ok = 0;
            end
            if (Done) begin
                obs_t = t; fin = 1;
            end else if (Error) begin
                obs_err = 1; obs_t = t; obs_code = ErrCode; fin = 1;
            end
            if (!fin) begin
                if (!hold) Despacho = (inj != 0 && t >= d + 3) ? 5'(inj) : 5'd0;
                Cup    = (t >= d) && !(drop && t >= d + 1 + p);
                Refill = refill_last && (t == d + POUR);
                step();
                t++;
            end
        end
        Refill = 1'b0;
        if (obs_err) begin
            Clear = 1'b1;
            step();
            Clear = 1'b0;
        end else begin
            step();
        end
        obs_busy_after = Busy; obs_errcode_after = ErrCode;
        obs_done_after = Done; obs_error_after = Error;
    endtask

    task automatic pulse_refill();
        Refill = 1'b1;
        step();
        Refill = 1'b0;
        model_refill();
    endtask

    task automatic test_reset();
        reset = 1'b0; Despacho = 5'd0; Cup = 1'b0; Clear = 1'b0; Refill = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        model_refill();
        n_cmp++;
        if (Valve !== 8'd0) begin n_fail++; $display("FAIL reset_valve: got %b expected 0", Valve); end
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b done=%b err=%b expected 0", Busy, Done, Error);
        end
        n_cmp++;
        if (Empty !== 8'd0) begin n_fail++; $display("FAIL reset_empty: got %b expected 0", Empty); end
        n_cmp++;
        if (ErrCode !== 2'b00) begin n_fail++; $display("FAIL reset_errcode: got %b expected 00", ErrCode); end
    endtask

    task automatic test_reset_mid_pour();
        Despacho = 5'd0; Cup = 1'b1;
        step();
        Despacho = 5'd4;
        step(); step(); step(); step();
        n_cmp++;
        if (Valve !== 8'b0000_1000) begin n_fail++; $display("FAIL midpour_open: got %b expected 00001000", Valve); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (Valve !== 8'd0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL midpour_async: got valve=%b busy=%b expected 0/0", Valve, Busy);
        end
        step();
        Despacho = 5'd0; Cup = 1'b0;
        reset = 1'b1;
        step();
        model_refill();
    endtask

    task automatic test_basic_pour();
        predict(2, 0, 0, 0, 0);
        run_txn(2, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_err !== 1'b0 || obs_t !== exp_t) begin
            n_fail++; $display("FAIL basic_done_time: got err=%0d t=%0d expected err=0 t=%0d", obs_err, obs_t, exp_t);
        end
        n_cmp++;
        if (obs_vc !== exp_vc || !obs_onehot_ok) begin
            n_fail++; $display("FAIL basic_valve: got %0d cycles onehot=%0d expected %0d", obs_vc, obs_onehot_ok, exp_vc);
        end
        n_cmp++;
        if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL basic_after: got done=%b busy=%b expected 0/0", obs_done_after, obs_busy_after);
        end
    endtask

    task automatic test_cup_timeout();
        predict(3, 1000, 0, 0, 0);
        run_txn(3, 1000, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_err !== 1'b1 || obs_code !== 2'(exp_code) || obs_t !== exp_t) begin
            n_fail++; $display("FAIL timeout: got err=%0d code=%0d t=%0d expected 1/%0d/%0d", obs_err, obs_code, obs_t, exp_code, exp_t);
        end
        n_cmp++;
        if (obs_vc !== 0) begin n_fail++; $display("FAIL timeout_valve: got %0d open cycles expected 0", obs_vc); end
        n_cmp++;
        if (obs_busy_after !== 1'b0 || obs_errcode_after !== 2'b00 || obs_error_after !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: got busy=%b code=%b err=%b expected 0/00/0", obs_busy_after, obs_errcode_after, obs_error_after);
        end
        // Cup arriving in the very last waiting cycle still pours.
        predict(3, TO - 1, 0, 0, 0);
        run_txn(3, TO - 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_err !== 1'b0 || obs_t !== exp_t) begin
            n_fail++; $display("FAIL timeout_edge: got err=%0d t=%0d expected err=0 t=%0d", obs_err, obs_t, exp_t);
        end
    endtask

    task automatic test_cup_removed();
        predict(4, 0, 1, 10, 0);
        run_txn(4, 0, 1, 10, 0, 0, 0);
        n_cmp++;
        if (obs_code !== 2'b11 || obs_t !== exp_t) begin
            n_fail++; $display("FAIL removed: got code=%b t=%0d expected 11 t=%0d", obs_code, obs_t, exp_t);
        end
        n_cmp++;
        if (obs_vc !== exp_vc) begin n_fail++; $display("FAIL removed_valve: got %0d expected %0d", obs_vc, exp_vc); end
        n_cmp++;
        if (Empty !== exp_empty) begin n_fail++; $display("FAIL removed_empty: got %b expected %b", Empty, exp_empty); end
    endtask

    task automatic test_empty_refill();
        pulse_refill();
        for (int i = 0; i < SMAX; i++) begin
            predict(1, 0, 0, 0, 0);
            run_txn(1, 0, 0, 0, 0, 0, 0);
        end
        n_cmp++;
        if (Empty !== exp_empty || exp_empty !== 8'h01) begin
            n_fail++; $display("FAIL drain_empty: got %b expected %b", Empty, exp_empty);
        end
        predict(1, 0, 0, 0, 0);
        run_txn(1, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_code !== 2'(exp_code) || obs_t !== exp_t || obs_vc !== 0) begin
            n_fail++; $display("FAIL empty_fault: got code=%b t=%0d vc=%0d expected %0d/%0d/0", obs_code, obs_t, obs_vc, exp_code, exp_t);
        end
        pulse_refill();
        n_cmp++;
        if (Empty !== 8'd0) begin n_fail++; $display("FAIL refill_empty: got %b expected 0", Empty); end
    endtask

    task automatic test_refill_coincide();
        pulse_refill();
        predict(2, 0, 0, 0, 1);
        run_txn(2, 0, 0, 0, 0, 0, 1);
        // SMAX-1 left: SMAX-2 pours keep it non-empty, one more empties it.
        for (int i = 0; i < SMAX - 2; i++) begin
            predict(2, 0, 0, 0, 0);
            run_txn(2, 0, 0, 0, 0, 0, 0);
        end
        n_cmp++;
        if (Empty[1] !== exp_empty[1] || exp_empty[1] !== 1'b0) begin
            n_fail++; $display("FAIL coincide_left1: got %b expected %b", Empty[1], exp_empty[1]);
        end
        predict(2, 0, 0, 0, 0);
        run_txn(2, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (Empty[1] !== exp_empty[1] || exp_empty[1] !== 1'b1) begin
            n_fail++; $display("FAIL coincide_left0: got %b expected %b", Empty[1], exp_empty[1]);
        end
        pulse_refill();
    endtask

    task automatic test_misc();
        int codes [2] = '{9, 31};
        predict(5, 0, 0, 0, 0);
        run_txn(5, 0, 0, 0, 1, 0, 0);
        repeat (5) step();
        n_cmp++;
        if (Busy !== 1'b0 || Valve !== 8'd0) begin
            n_fail++; $display("FAIL held_code: got busy=%b valve=%b expected 0/0", Busy, Valve);
        end
        foreach (codes[i]) begin
            Despacho = 5'd0;
            step();
            Despacho = 5'(codes[i]);
            repeat (3) step();
            n_cmp++;
            if (Busy !== 1'b0 || Error !== 1'b0) begin
                n_fail++; $display("FAIL invalid_code %0d: got busy=%b err=%b expected 0/0", codes[i], Busy, Error);
            end
        end
        predict(6, 1, 0, 0, 0);
        run_txn(6, 1, 0, 0, 0, 7, 0);
        n_cmp++;
        if (obs_vc !== exp_vc || !obs_onehot_ok || obs_t !== exp_t) begin
            n_fail++; $display("FAIL inject: got vc=%0d onehot=%0d t=%0d expected %0d/1/%0d", obs_vc, obs_onehot_ok, obs_t, exp_vc, exp_t);
        end
        repeat (4) step();
        n_cmp++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL inject_dropped: got busy=%b expected 0", Busy); end
        Despacho = 5'd0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int code, d, p;
            bit drop;
            if ($urandom_range(0, 7) == 0) pulse_refill();
            code = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 2) : $urandom_range(1, 8);
            d    = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 5) : $urandom_range(TO - 2, TO + 2);
            drop = ($urandom_range(0, 3) == 0);
            p    = $urandom_range(0, POUR - 1);
            predict(code, d, drop, p, 0);
            run_txn(code, d, drop, p, 0, 0, 0);
            n_cmp++;
            if (obs_err !== exp_err || obs_t !== exp_t || obs_code !== 2'(exp_code)) begin
                n_fail++; $display("FAIL rnd_outcome #%0d: got err=%0d code=%0d t=%0d expected %0d/%0d/%0d", i, obs_err, obs_code, obs_t, exp_err, exp_code, exp_t);
            end
            n_cmp++;
            if (obs_vc !== exp_vc || !obs_onehot_ok) begin
                n_fail++; $display("FAIL rnd_valve #%0d: got vc=%0d onehot=%0d expected %0d/1", i, obs_vc, obs_onehot_ok, exp_vc);
            end
            n_cmp++;
            if (obs_busy_after !== 1'b0 || obs_errcode_after !== 2'b00) begin
                n_fail++; $display("FAIL rnd_idle #%0d: got busy=%b code=%b expected 0/00", i, obs_busy_after, obs_errcode_after);
            end
            n_cmp++;
            if (Empty !== exp_empty) begin
                n_fail++; $display("FAIL rnd_empty #%0d: got %b expected %b", i, Empty, exp_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pour();
        test_cup_timeout();
        test_cup_removed();
        test_empty_refill();
        test_refill_coincide();
        test_misc();
        test_reset_mid_pour();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dispense_valve_ctrl.md
Name: dispense_valve_ctrl

Overview:
- Downstream stage of FSM_Principal: consumes its 5-bit Despacho code and physically pours the selected beverage.
- Opens one of 8 valves for a fixed pour time, but only while a cup is present.
- Tracks remaining servings per valve and reports completion or fault back to the menu logic and the display.

Parameters:
POUR_CYCLES, 20, clock cycles a valve stays open per serving (>=1)
CUP_TIMEOUT, 50, max cycles waiting for cup after a request (>=1)
STOCK_W, 4, width of each per-valve serving counter
STOCK_MAX, 15, servings loaded at reset/refill (<= 2^STOCK_W-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Despacho  input  5  beverage code from FSM_Principal; 0 = none, 1..8 = valve index+1, 9..31 invalid
Cup  input  1  cup-present sensor, synchronous, level
Clear  input  1  acknowledge/clear fault, level
Refill  input  1  reload all stock counters, single-cycle pulse
Valve  output  8  one-hot valve drive; Valve[k] serves code k+1
Busy  output  1  high in any state except IDLE
Done  output  1  one-cycle pulse when a serving completes
Error  output  1  high while in FAULT
ErrCode  output  2  00 none, 01 stock empty, 10 cup timeout, 11 cup removed mid-pour
Empty  output  8  Empty[k]=1 when stock[k]==0

Behaviour:
- Reset (reset=0, async): state=IDLE, Valve=0, Busy=0, Done=0, Error=0, ErrCode=00, all stocks=STOCK_MAX, Empty=0, latched code=0, prev Despacho register=0. A reset mid-pour closes the valve immediately, without waiting for a clock edge.
- Request detection: a request is a cycle in which Despacho!=0 and the registered previous Despacho==0. A request is accepted only in IDLE; requests in any other state are dropped and not queued.
- Moore FSM, states IDLE, WAIT_CUP, POUR, DONE, FAULT:
- IDLE:
  - Request with code 9..31: ignored; stay in IDLE.
  - Request with code 1..8: latch idx=code-1. If stock[idx]==0, go to FAULT with ErrCode=01. Otherwise go to WAIT_CUP and load the timeout counter with CUP_TIMEOUT-1.
- WAIT_CUP:
  - Cup=1: go to POUR and load the pour counter with POUR_CYCLES-1.
  - Cup=0 with timeout counter==0: go to FAULT with ErrCode=10.
  - Otherwise decrement the timeout counter.
  - Cup is sampled every cycle, including the first cycle in this state, so the state lasts at most CUP_TIMEOUT cycles.
- POUR:
  - Valve[idx]=1; all other valve bits 0.
  - Cup=0 in any POUR cycle: go to FAULT with ErrCode=11; the valve closes on the next cycle. Stock is not decremented.
  - Pour counter==0 with Cup=1: go to DONE and decrement stock[idx].
  - Otherwise decrement the pour counter.
  - A full pour holds the valve open for exactly POUR_CYCLES cycles.
- DONE: Done=1 for exactly one cycle, Valve=0, then go to IDLE. Next request latency from IDLE is 1 cycle.
- FAULT:
  - Error=1; ErrCode holds its value; Valve=0.
  - Clear=1: go to IDLE and set ErrCode=00. Clear has no effect in other states.
- Refill:
  - In any state, sets all stocks to STOCK_MAX on that edge.
  - If it coincides with the POUR-to-DONE decrement, stock[idx]=STOCK_MAX-1 (refill applied first, then the decrement).
- Stock never wraps below 0; a 0 stock is only reachable via FAULT 01 and cannot be decremented.
- Empty is combinational from the stock counters.
- Only one valve is ever open at a time.
- Busy is combinational from state.

Test Plan:
- Reset with all inputs 0, then release → Valve=00000000, Busy=0, Empty=00000000, ErrCode=00. Assert reset low mid-POUR → Valve=0 before the next clk edge.
- Despacho 0→2, Cup=1 throughout → WAIT_CUP for 1 cycle, Valve=00000010 for exactly 20 cycles, Done pulse for 1 cycle, stock[1]=14, Busy=0 afterwards.
- Despacho 0→3, Cup held 0 → after 50 cycles Error=1, ErrCode=10, Valve never set. Clear=1 → IDLE, ErrCode=00.
- Code 4 pour with Cup dropped at cycle 10 of POUR → Valve=0 on the next cycle, ErrCode=11, stock[3] unchanged (15).
- 15 complete pours of code 1 → Empty[0]=1. 16th request → ErrCode=01 with no valve. Refill pulse → Empty[0]=0, stock[0]=15.
- Despacho held at 5 after completion: no second pour. Despacho=9 from IDLE: ignored. New request during POUR: ignored. Refill in the same cycle as pour completion on code 2 → stock[1]=14.
